// File: rtl/sub_mp_sequencer.sv
// sub_mp_sequencer -- multi-precision subtract controller.
//
// Streams NWORDS 32-bit limb pairs (least significant limb first) through one
// sub_br32bit slice. The borrow out of each limb is registered and fed into the
// next limb, so the operation computes A - B - start_bo on 32*NWORDS-bit
// operands at one limb per cycle.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   start, start_bo      begin an operation (IDLE only) with an initial borrow
//   busy                 high while an operation is in RUN or DRAIN
//   in_valid, in_ready   limb-pair input stream (in_op1 - in_op2)
//   in_op1, in_op2       minuend / subtrahend limb
//   out_valid, out_ready result-limb output stream
//   out_diff, out_last   registered result limb; last marks the MS limb
//   out_bi               final borrow, held from the last limb until next start
//   done                 one-cycle pulse the cycle after the last limb leaves
//
// Handshake: on both streams a transfer happens on a rising edge where valid
// and ready are both high. A producer holding valid keeps its data stable until
// the transfer; out_valid never drops without a transfer, and out_diff,
// out_last and out_bi stay stable while out_valid && !out_ready.

// One 32-bit subtract-with-borrow slice: diff = op1 - op2 - bo mod 2^32,
// bi set when the true result is negative.
module sub_br32bit (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        bo,
  output logic [31:0] diff,
  output logic        bi
);
  logic [32:0] full;

  // The 33rd bit of the widened subtraction is the borrow out.
  assign full = {1'b0, op1} - {1'b0, op2} - {32'd0, bo};
  assign diff = full[31:0];
  assign bi   = full[32];
endmodule

module sub_mp_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        start_bo,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_diff,
  output logic        out_last,
  output logic        out_bi,
  output logic        done
);
  localparam int CW = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic          borrow_r;
  logic [31:0]   diff;
  logic          bi;
  logic          accept;
  logic          last_limb;
  logic          out_fire;

  sub_br32bit u_sub (
    .op1  (in_op1),
    .op2  (in_op2),
    .bo   (borrow_r),
    .diff (diff),
    .bi   (bi)
  );

  assign out_fire  = out_valid && out_ready;
  assign last_limb = (cnt == CW'(NWORDS - 1));
  assign accept    = (state == RUN) && in_valid && in_ready;

  // Next state and stream control.
  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // The output register may be refilled in the same cycle it drains.
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && last_limb) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      borrow_r  <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_last  <= 1'b0;
      out_bi    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_d;
      // Only the MS limb leaves in DRAIN, so this is the single done pulse.
      done  <= (state == DRAIN) && out_fire;

      if (state == IDLE && start) begin
        borrow_r <= start_bo;
        cnt      <= '0;
        out_bi   <= 1'b0;
      end

      if (accept) begin
        out_diff  <= diff;
        out_last  <= last_limb;
        out_valid <= 1'b1;
        borrow_r  <= bi;
        cnt       <= cnt + CW'(1);
        if (last_limb) out_bi <= bi;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sub_mp_sequencer.sv
module tb_sub_mp_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_bo;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_diff;
  logic        out_last;
  logic        out_bi;
  logic        done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_diff[$];
  logic        got_last[$];
  logic        got_bi[$];

  sub_mp_sequencer #(.NWORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_bo  (start_bo),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_last  (out_last),
    .out_bi    (out_bi),
    .done      (done)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor: a limb transfers on the next rising edge when valid&&ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_diff.push_back(out_diff);
      got_last.push_back(out_last);
      got_bi.push_back(out_bi);
    end
    if (done) done_cnt++;
  end

  task automatic clear_sb();
    exp_q.delete();
    got_diff.delete();
    got_last.delete();
    got_bi.delete();
    done_cnt = 0;
  endtask

  // Driver: pulse start, then present the four limbs. With bubble set, in_valid
  // drops for a cycle after each limb and start (bo=1) is pulsed meanwhile.
  task automatic drive_op(input logic [127:0] a, input logic [127:0] b,
                          input logic bo, input bit bubble);
    start = 1'b1; start_bo = bo;
    @(posedge clk); #1;
    start = 1'b0; start_bo = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bit acc;
      int t;
      acc = 1'b0;
      t = 0;
      in_valid = 1'b1;
      in_op1 = a[k*32 +: 32];
      in_op2 = b[k*32 +: 32];
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        t++;
      end
      in_valid = 1'b0;
      if (!acc) begin
        checks++; errors++;
        $display("FAIL drive_timeout: limb %0d not accepted, in_ready=%b want 1", k, in_ready);
      end
      if (bubble && k < 3) begin
        start = 1'b1; start_bo = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_bo = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_bo = 1'b1;
    in_valid = 1'b1; in_op1 = 32'h1234_5678; in_op2 = 32'h0000_0001; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, in_ready, out_valid, out_last, out_bi, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy,in_ready,out_valid,out_last,out_bi,done=%b want 000000",
               {busy, in_ready, out_valid, out_last, out_bi, done});
    end
    checks++;
    if (out_diff !== 32'h0) begin
      errors++;
      $display("FAIL reset_diff: out_diff=%h want 00000000", out_diff);
    end
    @(posedge clk); #1;
    rst = 1'b0; start_bo = 1'b0;
  endtask

  task automatic test_idle_ignore();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op1 = 32'($urandom_range(0, 1000));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignore: in_ready=%b out_valid=%b busy=%b want 0 0 0",
                 in_ready, out_valid, busy);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Full-speed operation with exact latency and result checks.
  task automatic test_op(input string name, input logic [127:0] a, input logic [127:0] b,
                         input logic bo, input logic [127:0] exp, input logic exp_bi);
    clear_sb();
    for (int k = 0; k < 4; k++) exp_q.push_back(exp[k*32 +: 32]);
    drive_op(a, b, bo, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, busy, done} !== 4'b1110) begin
      errors++;
      $display("FAIL %s last_phase: valid,last,busy,done=%b want 1110", name,
               {out_valid, out_last, busy, done});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL %s done_phase: done,busy,out_valid=%b want 100", name, {done, busy, out_valid});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b count=%0d want 0 1", name, done, done_cnt);
    end
    checks++;
    if (got_diff.size() != 4) begin
      errors++;
      $display("FAIL %s limb_count: got %0d want 4", name, got_diff.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_diff[k] !== exp_q[k] || got_last[k] !== (k == 3)) begin
          errors++;
          $display("FAIL %s limb%0d: diff=%h last=%b want %h %b", name, k,
                   got_diff[k], got_last[k], exp_q[k], (k == 3));
        end
      end
      checks++;
      if (got_bi[3] !== exp_bi || out_bi !== exp_bi) begin
        errors++;
        $display("FAIL %s out_bi: at_last=%b held=%b want %b", name, got_bi[3], out_bi, exp_bi);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit seen;
    clear_sb();
    exp_q = '{32'h1010_1010, 32'h2020_2020, 32'h3030_3030, 32'h4040_4040};
    fork
      drive_op(128'h44444444_33333333_22222222_11111111,
               128'h04040404_03030303_02020202_01010101, 1'b0, 1'b0);
      begin
        for (int t = 0; t < 40 && got_diff.size() < 2; t++) begin
          @(posedge clk); #2;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_diff !== 32'h3030_3030 || out_last !== 1'b0 ||
              in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b diff=%h last=%b in_ready=%b want 1 30303030 0 0",
                     i, out_valid, out_diff, out_last, in_ready);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_done: done=%b want 1 within 20 cycles", done);
    end
    @(negedge clk);
    checks++;
    if (got_diff.size() != 4 || done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_count: limbs=%0d dones=%0d want 4 1", got_diff.size(), done_cnt);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_diff[k] !== exp_q[k] || got_last[k] !== (k == 3)) begin
          errors++;
          $display("FAIL bp_limb%0d: diff=%h last=%b want %h %b", k, got_diff[k], got_last[k],
                   exp_q[k], (k == 3));
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // A = 2^64, B = 2: borrow ripples through limbs 0 and 1, absorbed in limb 2.
  task automatic test_bubbles_restart();
    bit seen;
    clear_sb();
    exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    drive_op(128'h00000000_00000001_00000000_00000000, 128'h2, 1'b0, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bub_done: done=%b want 1 within 20 cycles", done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_diff.size() != 4 || done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bub_count: limbs=%0d dones=%0d busy=%b want 4 1 0",
               got_diff.size(), done_cnt, busy);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_diff[k] !== exp_q[k] || got_last[k] !== (k == 3)) begin
          errors++;
          $display("FAIL bub_limb%0d: diff=%h last=%b want %h %b", k, got_diff[k], got_last[k],
                   exp_q[k], (k == 3));
        end
      end
      checks++;
      if (out_bi !== 1'b0) begin
        errors++;
        $display("FAIL bub_bi: out_bi=%b want 0", out_bi);
      end
    end
    @(posedge clk); #1;
  endtask

  // Abort an A=0,B=1 op (borrow_r=1) after two limbs, then run a fresh op.
  task automatic test_reset_mid_op();
    start = 1'b1; start_bo = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_op1 = 32'h0; in_op2 = 32'h1;
    @(posedge clk); #1;
    in_op2 = 32'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, done} !== 3'b000 || out_diff !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: busy,out_valid,done=%b diff=%h want 000 00000000",
               {busy, out_valid, done}, out_diff);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_nodone: done=%b want 0", done);
    end
    @(posedge clk); #1;
    test_op("after_rst", 128'h00000001_00000000_00000000_00000000, 128'h1, 1'b0,
            128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_op("t1", 128'h00000001_00000000_00000000_00000000, 128'h1, 1'b0,
            128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0);
    test_op("t2", 128'h0, 128'h1, 1'b0,
            128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1);
    test_op("t3_bo1", 128'h7, 128'h4, 1'b1, 128'h2, 1'b0);
    test_op("t3_bo0", 128'h7, 128'h4, 1'b0, 128'h3, 1'b0);
    test_backpressure();
    test_bubbles_restart();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
